// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, credit-limited instruction FIFO, redirect flush.
// Optional FETCH_STATS_EN adds saturating pop/bubble counters (stat_fetched, stat_bubbles).
module fetch_unit #(
    parameter int unsigned             D_WIDTH    = 32,
    parameter int unsigned             A_WIDTH    = 32,
    parameter logic [A_WIDTH-1:0]      RESET_PC   = '0,
    parameter int unsigned             FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic               imem_rvalid,
    input  logic [D_WIDTH-1:0] imem_rdata,
    output logic [D_WIDTH-1:0] Instr,
    output logic [A_WIDTH-1:0] InstrPC,
    output logic               InstrValid,
    input  logic               DecodeReady,
    input  logic               PCSrc,
    input  logic [A_WIDTH-1:0] PCTarget
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_bubbles
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic               running_q;
    logic [A_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   disc_q, disc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W-1:0]   srd_q, srd_d, swr_q, swr_d;
    logic [D_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [A_WIDTH-1:0] fpc_q  [FIFO_DEPTH];
    logic [A_WIDTH-1:0] spc_q  [FIFO_DEPTH];

    logic               pop_c, drop_c, push_c, issue_c;
    logic [OCC_W-1:0]   occ_c;

    // A pop this cycle frees its slot for a new request, sustaining one word per cycle.
    always_comb begin
        pop_c   = (cnt_q != '0) && DecodeReady;
        drop_c  = imem_rvalid && (PCSrc || (disc_q != '0));
        push_c  = imem_rvalid && !drop_c;
        occ_c   = OCC_W'(out_q) + OCC_W'(cnt_q) - OCC_W'(pop_c);
        issue_c = running_q && !PCSrc && (occ_c < OCC_W'(FIFO_DEPTH));
    end

    assign imem_req   = issue_c;
    assign imem_addr  = pc_q;
    assign InstrValid = (cnt_q != '0);
    assign Instr      = data_q[rd_q];
    assign InstrPC    = fpc_q[rd_q];

    always_comb begin
        pc_d   = pc_q;
        disc_d = disc_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        srd_d  = srd_q;
        swr_d  = swr_q;
        out_d  = out_q + CNT_W'(issue_c) - CNT_W'(imem_rvalid);
        cnt_d  = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        if (issue_c) begin
            pc_d  = pc_q + A_WIDTH'(4);
            swr_d = swr_q + PTR_W'(1);
        end
        if (imem_rvalid) begin
            srd_d = srd_q + PTR_W'(1);
        end
        if (imem_rvalid && (disc_q != '0)) begin
            disc_d = disc_q - CNT_W'(1);
        end
        if (push_c) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_d = rd_q + PTR_W'(1);
        end
        // Redirect: every request still in flight becomes wrong-path, buffer is emptied.
        if (PCSrc) begin
            pc_d   = PCTarget & ~A_WIDTH'(3);
            disc_d = out_q - CNT_W'(imem_rvalid);
            cnt_d  = '0;
            rd_d   = wr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q <= 1'b0;
            pc_q      <= RESET_PC;
            out_q     <= '0;
            disc_q    <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            srd_q     <= '0;
            swr_q     <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_q[i] <= '0;
                fpc_q[i]  <= '0;
                spc_q[i]  <= '0;
            end
        end else begin
            running_q <= 1'b1;
            pc_q      <= pc_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            srd_q     <= srd_d;
            swr_q     <= swr_d;
            if (issue_c) begin
                spc_q[swr_q] <= pc_q;
            end
            // Shadow queue head is the PC of the request this response answers.
            if (push_c) begin
                data_q[wr_q] <= imem_rdata;
                fpc_q[wr_q]  <= spc_q[srd_q];
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q, bubbles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (pop_c && (fetched_q != '1)) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (DecodeReady && !InstrValid && (bubbles_q != '1)) begin
                bubbles_q <= bubbles_q + 32'd1;
            end
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_bubbles = bubbles_q;
`else
    // Statistics counters are not built.
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_c && (cnt_q == CNT_W'(FIFO_DEPTH))));
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && (out_q == '0)));

endmodule
